// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: op codes, FSM states, 7-seg patterns.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package calc_pkg;

    // func[1:0] operation select
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_e;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} pattern table for decimal digits; non-decimal codes blank
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 2*WIDTH-bit unsigned value to DIGITS BCD digits.
// Latency: 2*WIDTH cycles after start_i; done_o marks the last step with bcd_o valid alongside.
// Backpressure: start_i is ignored while busy_o is high; no stall once running.
module bin2bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2*WIDTH-1:0]    bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int NB    = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(NB) + 1;

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BW-1:0]      bcd_q;
    logic [NB-1:0]      bin_q;
    logic [BW-1:0]      adj;
    logic [BW+NB-1:0]   shifted;
    logic [NB-1:0]      bin_step;
    logic               last;

    // One double-dabble step: add 3 to every digit >= 5, then shift one binary bit in
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    assign bcd_o    = shifted[BW+NB-1:NB];
    assign bin_step = shifted[NB-1:0];
    assign last     = (cnt_q == CNT_W'(NB - 1));
    assign busy_o   = busy_q;
    assign done_o   = busy_q && last;

    // Load on start, then step once per cycle for NB cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bcd_q  <= '0;
            bin_q  <= '0;
        end else if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            bcd_q  <= '0;
            bin_q  <= bin_i;
        end else if (busy_q) begin
            bcd_q  <= bcd_o;
            bin_q  <= bin_step;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_calc_top.sv
// Sequential signed add/sub/mul/div with BCD and 7-segment presentation of the result.
// Latency: done pulses 1+2*WIDTH+1 cycles after acceptance for add/sub, WIDTH+2*WIDTH+1 for mul/div.
// Backpressure: start is accepted only in IDLE; requests while busy (including the DONE cycle) are dropped.
module seq_calc_top
    import calc_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            func,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    out,
    output logic                  err,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    state_e state_q, state_d;

    // Latched request
    op_e                op_q;
    logic               sel_q;
    logic [WIDTH-1:0]   a_q, b_q;

    // Iteration datapath: shift-add multiplier and restoring divider on magnitudes
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      prod_q, prod_d;
    logic [RW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in, mag_b;
    logic [WIDTH:0]     div_shift;

    // Result path
    logic [WIDTH:0]     addsub;
    logic               sgn_diff;
    logic [RW-1:0]      res_d, res_q, res_mag;
    logic               rerr_d, rerr_q;

    // Control
    logic               accept, calc_last;
    logic               conv_busy, conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    // Display path
    logic [7*DIGITS-1:0] seg_d;
    logic                lead_zero;
    logic [3:0]          digit;

    // Held outputs
    logic [RW-1:0]       out_q;
    logic                err_q, neg_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [7*DIGITS-1:0] seg_q;

    assign accept    = (state_q == IDLE) && start;
    assign calc_last = (state_q == CALC) &&
                       ((op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == CW'(WIDTH - 1)));

    assign mag_a_in  = a[WIDTH-1]   ? -a   : a;
    assign mag_b_in  = b[WIDTH-1]   ? -b   : b;
    assign mag_b     = b_q[WIDTH-1] ? -b_q : b_q;
    assign div_shift = {rem_q, quo_q[WIDTH-1]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs; busy covers every non-IDLE state so DONE also drops start
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (calc_last) state_d = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (conv_done) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration next-state: load magnitudes on acceptance, one mul and one div step per CALC cycle
    always_comb begin
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        if (accept) begin
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{WIDTH{1'b0}}, mag_a_in};
            mplr_d  = mag_b_in;
            quo_d   = mag_a_in;
            rem_d   = '0;
        end else if (state_q == CALC) begin
            cnt_d   = cnt_q + CW'(1);
            if (mplr_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            if (div_shift >= {1'b0, mag_b}) begin
                rem_d = WIDTH'(div_shift - {1'b0, mag_b});
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = div_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Iteration registers and latched request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_ADD;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            if (accept) begin
                op_q  <= op_e'(func[1:0]);
                sel_q <= func[2];
                a_q   <= a;
                b_q   <= b;
            end
        end
    end

    // Signed result from the final iteration values; only meaningful on the last CALC cycle
    always_comb begin
        sgn_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        addsub   = (op_q == OP_SUB) ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                                    : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});
        res_d    = '0;
        rerr_d   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_d  = {{(RW-WIDTH-1){addsub[WIDTH]}}, addsub};
                rerr_d = addsub[WIDTH] ^ addsub[WIDTH-1];
            end
            OP_MUL: begin
                res_d  = sgn_diff ? -prod_d : prod_d;
            end
            OP_DIV: begin
                if (mag_b == '0) begin
                    rerr_d = 1'b1;
                end else begin
                    res_d  = sgn_diff ? -{{WIDTH{1'b0}}, quo_d} : {{WIDTH{1'b0}}, quo_d};
                end
            end
            default: res_d = '0;
        endcase
        res_mag = res_d[RW-1] ? -res_d : res_d;
    end

    // Hold the signed result through conversion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q  <= '0;
            rerr_q <= 1'b0;
        end else if (calc_last) begin
            res_q  <= res_d;
            rerr_q <= rerr_d;
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (calc_last && !conv_busy),
        .bin_i   (res_mag),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // 7-seg encode, blanking zeros above the most significant non-zero digit; digit 0 always shown
    always_comb begin
        seg_d     = '1;
        lead_zero = 1'b1;
        digit     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit = conv_bcd[4*k +: 4];
            if ((k != 0) && lead_zero && (digit == 4'd0)) begin
                seg_d[7*k +: 7] = SEG_BLANK;
            end else begin
                lead_zero       = 1'b0;
                seg_d[7*k +: 7] = seg_encode(digit);
            end
        end
    end

    // Visible results change only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            err_q <= 1'b0;
            neg_q <= 1'b0;
            bcd_q <= '0;
            seg_q <= '1;
        end else if ((state_q == CONV) && conv_done) begin
            out_q <= sel_q ? {a_q, b_q} : res_q;
            err_q <= rerr_q;
            neg_q <= res_q[RW-1];
            bcd_q <= conv_bcd;
            seg_q <= seg_d;
        end
    end

    assign out = out_q;
    assign err = err_q;
    assign neg = neg_q;
    assign bcd = bcd_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seq_calc_top.sv
// Self-checking bench for seq_calc_top: directed corner cases plus randomized operations.
// Latency: each operation is tracked cycle by cycle from acceptance to the done pulse.
// Backpressure: extra start pulses are injected while busy and must be ignored.
module tb_seq_calc_top;

    localparam int W  = 6;
    localparam int D  = 4;
    localparam int RW = 2 * W;

    localparam logic [6:0] SEGTAB [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                           7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a, b;
    logic [2:0]     func;
    logic           busy, done, err, neg;
    logic [RW-1:0]  out;
    logic [4*D-1:0] bcd;
    logic [7*D-1:0] seg;

    int vectors     = 0;
    int miscompares = 0;
    int last_lat    = 0;

    seq_calc_top #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .func  (func),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err),
        .bcd   (bcd),
        .neg   (neg),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic and decimal digit extraction
    function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input logic [2:0] fi,
                                  output logic [RW-1:0] out_e, output logic err_e,
                                  output logic neg_e, output logic [4*D-1:0] bcd_e,
                                  output logic [7*D-1:0] seg_e, output int lat_e);
        int av, bv, res, mag, p, dg;
        av    = $signed(ai);
        bv    = $signed(bi);
        res   = 0;
        err_e = 1'b0;
        case (fi[1:0])
            2'd0:    res = av + bv;
            2'd1:    res = av - bv;
            2'd2:    res = av * bv;
            default: if (bv == 0) err_e = 1'b1; else res = av / bv;
        endcase
        if (!fi[1] && (res > (2 ** (W - 1)) - 1 || res < -(2 ** (W - 1)))) err_e = 1'b1;
        lat_e = (fi[1] ? W : 1) + 2 * W + 1;
        out_e = fi[2] ? {ai, bi} : RW'(res);
        neg_e = (res < 0);
        mag   = (res < 0) ? -res : res;
        p     = 1;
        bcd_e = '0;
        seg_e = '1;
        for (int k = 0; k < D; k++) begin
            dg = (mag / p) % 10;
            bcd_e[4*k +: 4] = 4'(dg);
            seg_e[7*k +: 7] = (k > 0 && mag < p) ? 7'h7F : SEGTAB[dg];
            p = p * 10;
        end
    endfunction

    // Issue one operation and check timing, results and single done pulse
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [2:0] fi,
                          input int poke_cyc, input bit poke_done, input bit watch);
        logic [RW-1:0]  out_e;
        logic           err_e, neg_e;
        logic [4*D-1:0] bcd_e;
        logic [7*D-1:0] seg_e;
        int             lat_e, cyc, extra;
        bit             busy_ok;
        model(ai, bi, fi, out_e, err_e, neg_e, bcd_e, seg_e, lat_e);
        @(negedge clk);
        start = 1'b1; a = ai; b = bi; func = fi;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); func = 3'($urandom);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (cyc == poke_cyc);
            @(negedge clk);
            cyc++;
        end
        start    = poke_done;
        last_lat = cyc;
        check("latency", cyc, lat_e);
        check("busy_span", busy_ok, 1'b1);
        check("out", out, out_e);
        check("err", err, err_e);
        check("neg", neg, neg_e);
        check("bcd", bcd, bcd_e);
        check("seg", seg, seg_e);
        @(negedge clk);
        start = 1'b0;
        check("done_width", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        if (watch) begin
            extra = 0;
            repeat (25) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            check("ignored_start", extra, 0);
        end
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; func = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", out, '0);
        check("rst_err", err, 1'b0);
        check("rst_bcd", bcd, '0);
        check("rst_neg", neg, 1'b0);
        check("rst_seg", seg, {(7*D){1'b1}});
        rst_n = 1'b1;

        // add 5 + (-3)
        run_op(W'(5), W'(-3), 3'b000, -1, 1'b0, 1'b0);
        check("add_lat", last_lat, 14);
        check("add_out", out, 12'h002);
        check("add_bcd", bcd, 16'h0002);
        check("add_neg", neg, 1'b0);
        check("add_err", err, 1'b0);

        // mul -32 * -32
        run_op(W'(-32), W'(-32), 3'b010, -1, 1'b0, 1'b0);
        check("mul_lat", last_lat, 19);
        check("mul_out", out, 12'h400);
        check("mul_bcd", bcd, 16'h1024);
        check("mul_err", err, 1'b0);

        // div -17 / 4, then divide by zero
        run_op(W'(-17), W'(4), 3'b011, -1, 1'b0, 1'b0);
        check("div_out", out, 12'hFFC);
        check("div_neg", neg, 1'b1);
        check("div_bcd", bcd, 16'h0004);
        run_op(W'(7), W'(0), 3'b011, -1, 1'b0, 1'b0);
        check("div0_out", out, 12'h000);
        check("div0_err", err, 1'b1);

        // sub overflow -32 - 1
        run_op(W'(-32), W'(1), 3'b001, -1, 1'b0, 1'b0);
        check("sub_out", out, 12'hFDF);
        check("sub_err", err, 1'b1);
        check("sub_bcd", bcd, 16'h0033);
        check("sub_neg", neg, 1'b1);

        // result 7: digit 0 lit, upper digits blanked
        run_op(W'(3), W'(4), 3'b000, -1, 1'b0, 1'b0);
        check("seg_d0", seg[6:0], 7'b0001111);
        check("seg_hi", seg[7*D-1:7], {(7*(D-1)){1'b1}});

        // out-select returns the latched operands
        run_op(W'(-5), W'(9), 3'b110, -1, 1'b0, 1'b0);
        check("sel_out", out, {W'(-5), W'(9)});

        // start pulsed at cycle 5 of a mul and during DONE is ignored
        run_op(W'(3), W'(7), 3'b010, 5, 1'b1, 1'b1);

        // reset in the middle of CONV aborts the operation
        @(negedge clk);
        start = 1'b1; a = W'(9); b = W'(7); func = 3'b010;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("conv_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out", out, '0);
        check("abort_seg", seg, {(7*D){1'b1}});
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        // randomized operations, some with stray start pulses while busy
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 3'($urandom),
                   ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 12)) : -1,
                   1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
